coin_sequencer: RTL
===================

# coin_sequencer

Upstream front-end of the vending datapath: turns raw coin-slot and push-button inputs into the registered `sw_credito` credit value, the 3-bit `estado` code and the single-cycle `avance` strobe. The existing credit-check, state-control and 7-segment display logic consume these outputs directly. The block owns all sequential behaviour: synchronisation, debounce, credit accumulation, the vend/change state machine and change payout.

## Interface
Parameters:
- `PRICE`, 5: credit units consumed per vend; legal range 1..15.
- `DEB_CYCLES`, 16: consecutive stable cycles needed to accept a new input level; must be ≥ 2.
- `DISPENSE_CYCLES`, 8: cycles spent in DISPENSA; must be ≥ 1.

Ports:
- `clk`  in  1  single system clock; all flops on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `coin_1`  in  1  raw coin slot worth 1 unit; asynchronous, may bounce.
- `coin_2`  in  1  raw coin slot worth 2 units; asynchronous, may bounce.
- `btn_avance`  in  1  raw vend-request button.
- `btn_cancel`  in  1  raw cancel/refund button.
- `sw_credito`  out  4  current credit, unsigned, registered.
- `estado`  out  3  state code, registered.
- `avance`  out  1  one-cycle vend strobe, registered.
- `busy`  out  1  high in DISPENSA and CAMBIO.

## Operation
- Each raw input passes through a 2-flop synchroniser, then the debouncer, then a rising-edge detector that produces a 1-cycle event pulse. A held input yields exactly one pulse.
- Credit is a 4-bit register. A `coin_1` pulse adds 1 and a `coin_2` pulse adds 2. Both pulses in the same cycle add 3. The sum saturates at 15, and excess is lost.
- States and `estado` codes:
  - IDLE = 0: credit is 0.
  - CARGA = 1: 0 < credit < PRICE.
  - LISTO = 2: credit ≥ PRICE.
  - DISPENSA = 3.
  - CAMBIO = 4.
  - Codes 5..7 are unused. Any illegal state returns to IDLE.
- IDLE, CARGA and LISTO are re-evaluated every cycle from the post-update credit.
- In LISTO, an avance pulse moves the block to DISPENSA.
  - On the transition edge, credit becomes credit − PRICE.
  - `avance` is high for exactly the first DISPENSA cycle.
  - Any coin pulse in that same cycle is discarded.
- An avance pulse in IDLE or CARGA is ignored.
- DISPENSA lasts exactly DISPENSE_CYCLES cycles, then goes to CAMBIO if credit > 0, otherwise to IDLE.
- In CARGA or LISTO, a cancel pulse moves the block to CAMBIO. Cancel has priority over avance in the same cycle. Cancel in IDLE is ignored.
- CAMBIO pays out change by decrementing credit by 1 per cycle. It leaves for IDLE on the cycle credit reaches 0.
- Coin, avance and cancel pulses are discarded while `busy`.

## Timing
- Reset values: state IDLE, `estado` = 0, `sw_credito` = 0, `avance` = 0, `busy` = 0. Synchroniser, debounce and edge flops are 0.
- Reset mid-DISPENSA or mid-CAMBIO aborts the operation with no `avance` glitch. Credit is lost.
- Input latency with debounce: a clean rising edge on a raw input gives its event pulse 2 + DEB_CYCLES + 1 cycles later.
- Credit latency: `sw_credito` and `estado` update on the cycle after the event pulse. They are always mutually consistent.
- A bounce shorter than DEB_CYCLES yields no pulse.
- Vend timing: `avance` rises in the same cycle that `estado` first shows 3. `busy` is high from that cycle through the last CAMBIO cycle.
- CAMBIO duration equals the credit on entry, in cycles.

## Configuration
- `COIN_DEBOUNCE_EN` defined:
  - debounce counter present, sized as `$clog2(DEB_CYCLES)+1` bits;
  - the accepted level toggles only after DEB_CYCLES stable cycles;
  - event latency is DEB_CYCLES + 3.
- `COIN_DEBOUNCE_EN` undefined:
  - debounce logic is removed and the synchroniser output feeds the edge detector directly;
  - event latency is 3 cycles;
  - `DEB_CYCLES` is ignored.

## Structure
- Shared package `vending_pkg`:
  - the state enum (IDLE..CAMBIO with the codes above);
  - credit width (4);
  - `CREDIT_MAX` (15).
- One sub-module, `input_conditioner`: synchroniser, optional debounce and edge detect for one input. It is instantiated four times.
- The FSM and credit register live in `coin_sequencer`.

## Test plan
All cases are run with `COIN_DEBOUNCE_EN` defined and default parameters unless stated.
- `coin_2` ×2 then `coin_1` ×1 with clean edges → `sw_credito` steps 2, 4, 5; `estado` steps 1, 1, 2. Then avance → `avance` high for 1 cycle, `estado` = 3, credit 0, `busy` high for 8 cycles, then `estado` = 0.
- Credit 7, avance → DISPENSA for 8 cycles, then CAMBIO with credit 2→1→0 over 2 cycles, then IDLE with `busy` = 0.
- Credit 3 (CARGA), cancel and avance asserted in the same cycle → CAMBIO, 3 decrement cycles, no `avance` pulse.
- `coin_1` bouncing in 5-cycle bursts, then held → exactly one credit increment, 19 cycles after the final stable edge.
- Credit 14, simultaneous `coin_1` and `coin_2` pulses → credit saturates at 15, `estado` = 2. Coins inserted during DISPENSA leave credit unchanged.
- Assert `rst` mid-CAMBIO → all outputs 0 asynchronously. Rebuild with `COIN_DEBOUNCE_EN` undefined → coin pulse latency of 3 cycles.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending front-end.
package vending_pkg;

  localparam int unsigned CREDIT_W = 4;

  typedef logic [CREDIT_W-1:0] credit_t;

  localparam credit_t CREDIT_MAX = credit_t'(15);

  // Encodings are visible on the estado output and must not change.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StCarga    = 3'd1,
    StListo    = 3'd2,
    StDispensa = 3'd3,
    StCambio   = 3'd4
  } state_e;

  // Credit plus a 0..3 coin value, clamped at CREDIT_MAX.
  function automatic credit_t sat_add(credit_t a, logic [1:0] inc);
    logic [CREDIT_W:0] sum;
    sum = {1'b0, a} + {{(CREDIT_W - 1){1'b0}}, inc};
    if (sum > {1'b0, CREDIT_MAX}) begin
      return CREDIT_MAX;
    end
    return sum[CREDIT_W-1:0];
  endfunction

  // Resting state implied by a credit value outside a vend or refund.
  function automatic state_e rest_state(credit_t c, credit_t price);
    if (c == '0) begin
      return StIdle;
    end else if (c < price) begin
      return StCarga;
    end
    return StListo;
  endfunction

endpackage

// File: rtl/input_conditioner.sv
// One raw asynchronous input -> 2-flop synchroniser -> optional debounce -> rising-edge pulse.
// Debounce is built only when COIN_DEBOUNCE_EN is defined; otherwise DEB_CYCLES is ignored.
module input_conditioner #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_q;

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef COIN_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEB_CYCLES) + 1;

  logic [CntW-1:0] cnt;
  logic            stable;

  // Accepted level flips only after DEB_CYCLES consecutive cycles at the new value;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 != stable) begin
      if (cnt == CntW'(DEB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign level = stable;
`else
  logic unused_deb_cycles;
  assign unused_deb_cycles = ^DEB_CYCLES;
  assign level = sync2;
`endif

  // Registered rising-edge detect: one pulse per accepted 0->1 transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/coin_sequencer.sv
// Vending front-end: conditions coin/button inputs, accumulates credit and runs the
// vend/change state machine. Debounce is enabled with the COIN_DEBOUNCE_EN macro.
module coin_sequencer
  import vending_pkg::*;
#(
  parameter int unsigned PRICE           = 5,
  parameter int unsigned DEB_CYCLES      = 16,
  parameter int unsigned DISPENSE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_1,
  input  logic                coin_2,
  input  logic                btn_avance,
  input  logic                btn_cancel,
  output logic [CREDIT_W-1:0] sw_credito,
  output logic [2:0]          estado,
  output logic                avance,
  output logic                busy
);

  localparam int unsigned DispW  = $clog2(DISPENSE_CYCLES) + 1;
  localparam credit_t     PriceC = credit_t'(PRICE);

  logic p_coin1;
  logic p_coin2;
  logic p_avance;
  logic p_cancel;

  input_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_coin1 (
    .clk  (clk),
    .rst  (rst),
    .raw  (coin_1),
    .pulse(p_coin1)
  );

  input_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_coin2 (
    .clk  (clk),
    .rst  (rst),
    .raw  (coin_2),
    .pulse(p_coin2)
  );

  input_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_avance (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_avance),
    .pulse(p_avance)
  );

  input_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_cancel (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_cancel),
    .pulse(p_cancel)
  );

  state_e           state_q;
  state_e           state_d;
  credit_t          credit_q;
  credit_t          credit_d;
  logic [DispW-1:0] dcnt_q;
  logic [DispW-1:0] dcnt_d;
  logic             avance_q;
  logic             busy_q;
  logic [1:0]       coin_inc;

  assign coin_inc = {p_coin2, p_coin1};

  // Next-state and next-credit; busy states ignore every input pulse.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    dcnt_d   = dcnt_q;
    case (state_q)
      StIdle, StCarga, StListo: begin
        if (p_cancel && (state_q != StIdle)) begin
          // Coins landing with the cancel are still refunded.
          credit_d = sat_add(credit_q, coin_inc);
          state_d  = StCambio;
        end else if (p_avance && (state_q == StListo)) begin
          // Coins arriving on the vend edge are dropped.
          credit_d = credit_q - PriceC;
          dcnt_d   = '0;
          state_d  = StDispensa;
        end else begin
          credit_d = sat_add(credit_q, coin_inc);
          state_d  = rest_state(credit_d, PriceC);
        end
      end
      StDispensa: begin
        if (dcnt_q == DispW'(DISPENSE_CYCLES - 1)) begin
          state_d = (credit_q != '0) ? StCambio : StIdle;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      StCambio: begin
        // One unit paid per cycle; leave on the cycle the last unit goes out.
        if (credit_q != '0) begin
          credit_d = credit_q - credit_t'(1);
        end
        if (credit_q <= credit_t'(1)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        credit_d = '0;
      end
    endcase
  end

  // State, credit and registered strobes; avance marks only the DISPENSA entry cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      credit_q <= '0;
      dcnt_q   <= '0;
      avance_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      dcnt_q   <= dcnt_d;
      avance_q <= (state_d == StDispensa) && (state_q != StDispensa);
      busy_q   <= (state_d == StDispensa) || (state_d == StCambio);
    end
  end

  assign sw_credito = credit_q;
  assign estado     = state_q;
  assign avance     = avance_q;
  assign busy       = busy_q;

endmodule
